// File: rtl/switchbox_config_loader.sv
// Configuration loader for one switch box tile. Words stream into a shadow
// register. The complete image reaches config_out in one step, so the muxes never see a partial load.
module switchbox_config_loader #(
    parameter int CONFIG_WIDTH = 384,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_start,
    input  logic [WORD_WIDTH-1:0]   cfg_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic                    cfg_done,
    output logic                    cfg_error,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [CONFIG_WIDTH-1:0] shadow_reg;
    logic [CONFIG_WIDTH-1:0] shadow_next;
    logic [CONFIG_WIDTH-1:0] config_reg;
    logic                    ready_reg;
    logic                    done_reg;
    logic                    error_reg;

    // A new word enters at the top and the image shifts down one word.
    // After a full load, the first word sent is in the lowest bits.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_shift
            assign shadow_next[gi*WORD_WIDTH +: WORD_WIDTH] =
                shadow_reg[(gi+1)*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate
    assign shadow_next[CONFIG_WIDTH-1 -: WORD_WIDTH] = cfg_data;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            shadow_reg <= '0;
            config_reg <= '0;
            ready_reg  <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_start) begin
                        state_reg <= LOAD;
                        count_reg <= '0;
                        error_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end else if (cfg_valid) begin
                        error_reg <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart takes priority over a word offered on the same edge.
                    // Stale shadow bits are left in place because the next load overwrites all of them.
                    if (cfg_start) begin
                        count_reg <= '0;
                    end else if (cfg_valid) begin
                        shadow_reg <= shadow_next;
                        count_reg  <= count_reg + CNT_W'(1);
                        if (count_reg == LAST_COUNT) begin
                            state_reg <= COMMIT;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    config_reg <= shadow_reg;
                    done_reg   <= 1'b1;
                    state_reg  <= IDLE;
                    if (cfg_valid) begin
                        error_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready  = ready_reg;
    assign cfg_done   = done_reg;
    assign cfg_error  = error_reg;
    assign config_out = config_reg;

endmodule

// File: tb/tb_switchbox_config_loader.sv
// Bench for switchbox_config_loader. A model built on a word queue is checked against the DUT on every cycle.
// The directed scenarios add literal expectations, and a randomized loop follows them.
module tb_switchbox_config_loader;

    localparam int CW = 384;
    localparam int WW = 8;
    localparam int NW = CW / WW;

    logic          clock     = 1'b0;
    logic          nreset    = 1'b0;
    logic          cfg_start = 1'b0;
    logic [WW-1:0] cfg_data  = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_error;
    logic [CW-1:0] config_out;

    switchbox_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .cfg_start  (cfg_start),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .config_out (config_out)
    );

    always #5 clock = ~clock;

    int  tests  = 0;
    int  fails  = 0;
    int  cycle  = 0;
    bit  chk_en = 1'b0;

    // Model state: the words of the current load and the image last committed.
    bit            m_loading = 1'b0;
    bit            m_commit  = 1'b0;
    logic [WW-1:0] m_words[$];
    logic [CW-1:0] m_cfg  = '0;
    logic          m_done = 1'b0;
    logic          m_err  = 1'b0;

    always @(posedge clock) begin
        cycle++;
        if (!nreset) begin
            m_loading = 1'b0;
            m_commit  = 1'b0;
            m_words.delete();
            m_cfg  = '0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_commit) begin
                for (int k = 0; k < NW; k++) m_cfg[k*WW +: WW] = m_words[k];
                m_done   = 1'b1;
                m_commit = 1'b0;
                if (cfg_valid) m_err = 1'b1;
            end else if (m_loading) begin
                if (cfg_start) begin
                    m_words.delete();
                end else if (cfg_valid) begin
                    m_words.push_back(cfg_data);
                    if (m_words.size() == NW) begin
                        m_loading = 1'b0;
                        m_commit  = 1'b1;
                    end
                end
            end else if (cfg_start) begin
                m_loading = 1'b1;
                m_words.delete();
                m_err = 1'b0;
            end else if (cfg_valid) begin
                m_err = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            tests++;
            if (cfg_ready !== m_loading) begin
                fails++;
                $display("FAIL cyc%0d ready: got %b want %b", cycle, cfg_ready, m_loading);
            end
            tests++;
            if (cfg_done !== m_done) begin
                fails++;
                $display("FAIL cyc%0d done: got %b want %b", cycle, cfg_done, m_done);
            end
            tests++;
            if (cfg_error !== m_err) begin
                fails++;
                $display("FAIL cyc%0d error: got %b want %b", cycle, cfg_error, m_err);
            end
            tests++;
            if (config_out !== m_cfg) begin
                fails++;
                $display("FAIL cyc%0d config_out: got %h want %h", cycle, config_out, m_cfg);
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Offer one word and hold it until the edge that accepts it.
    task automatic send_word(input logic [WW-1:0] d);
        bit acc;
        acc       = 1'b0;
        cfg_data  = d;
        cfg_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clock);
            acc = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_word timeout: got no accept want accept within 100 cycles");
        end
    endtask

    logic [CW-1:0] ramp_img;

    initial begin
        for (int k = 0; k < NW; k++) ramp_img[k*WW +: WW] = WW'(k);

        tick();
        chk_en = 1'b1;
        tick();
        check_bit("reset_ready", cfg_ready, 1'b0);
        check_bit("reset_done", cfg_done, 1'b0);
        check_bit("reset_error", cfg_error, 1'b0);
        check_vec("reset_config", config_out, '0);
        nreset = 1'b1;
        tick();

        // Full load of the ramp 0..47 with no gaps.
        pulse_start();
        for (int k = 0; k < NW; k++) send_word(WW'(k));
        check_bit("full_no_early_done", cfg_done, 1'b0);
        tick();
        check_bit("full_done", cfg_done, 1'b1);
        check_vec("full_byte0", CW'(config_out[7:0]), CW'(8'h00));
        check_vec("full_byte1", CW'(config_out[15:8]), CW'(8'h01));
        check_vec("full_byte47", CW'(config_out[383:376]), CW'(8'h2F));
        check_bit("full_error", cfg_error, 1'b0);
        tick();
        check_bit("full_done_drop", cfg_done, 1'b0);
        $display("[TB] full load: config_out low byte %h top byte %h", config_out[7:0], config_out[383:376]);

        // Same ramp with a one-cycle bubble after every word.
        pulse_start();
        for (int k = 0; k < NW; k++) begin
            send_word(WW'(k));
            if (k < NW - 1) begin
                check_bit("bubble_no_done", cfg_done, 1'b0);
                tick();
            end
        end
        tick();
        check_bit("bubble_done", cfg_done, 1'b1);
        check_vec("bubble_image", config_out, ramp_img);
        tick();
        $display("[TB] bubble load: image %s", (config_out === ramp_img) ? "ok" : "bad");

        // Commit an all-A5 image, then start a 3C load that never completes.
        pulse_start();
        for (int k = 0; k < NW; k++) send_word(8'hA5);
        tick();
        tick();
        check_vec("a5_image", config_out, {NW{8'hA5}});
        pulse_start();
        for (int k = 0; k < 30; k++) begin
            send_word(8'h3C);
            check_vec("atomic_hold", config_out, {NW{8'hA5}});
        end
        $display("[TB] atomicity: config_out after 30 words %h", config_out[7:0]);

        // Abort the 3C load and replace it with all FF.
        pulse_start();
        for (int k = 0; k < NW; k++) begin
            send_word(8'hFF);
            check_bit("abort_no_early_done", cfg_done, 1'b0);
        end
        tick();
        check_bit("abort_done", cfg_done, 1'b1);
        check_vec("abort_image", config_out, {CW{1'b1}});
        tick();
        $display("[TB] abort: image all ones %b", &config_out);

        // A word offered in IDLE is a protocol error.
        cfg_valid = 1'b1;
        cfg_data  = 8'h77;
        tick();
        cfg_valid = 1'b0;
        check_bit("proto_error_set", cfg_error, 1'b1);
        check_vec("proto_config_kept", config_out, {CW{1'b1}});
        pulse_start();
        check_bit("proto_error_clear", cfg_error, 1'b0);
        $display("[TB] protocol error: flag cleared by start -> %b", cfg_error);

        // Reset after 20 words of this load.
        for (int k = 0; k < 20; k++) send_word(WW'(k));
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check_vec("midreset_config", config_out, '0);
        check_bit("midreset_ready", cfg_ready, 1'b0);
        pulse_start();
        for (int k = 0; k < NW; k++) send_word(WW'(k));
        tick();
        check_bit("reload_done", cfg_done, 1'b1);
        check_vec("reload_image", config_out, ramp_img);
        tick();
        $display("[TB] reset mid-load then reload: image %s", (config_out === ramp_img) ? "ok" : "bad");

        // Randomized loads with stray words, aborts, gaps and traffic during COMMIT.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = WW'($urandom);
                tick();
                cfg_valid = 1'b0;
            end
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_data  = WW'($urandom);
            pulse_start();
            cfg_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(0, NW - 1);
                for (int k = 0; k < n; k++) send_word(WW'($urandom));
                cfg_start = 1'b1;
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data  = WW'($urandom);
                tick();
                cfg_start = 1'b0;
                cfg_valid = 1'b0;
            end
            for (int k = 0; k < NW; k++) begin
                send_word(WW'($urandom));
                if (k < NW - 1) repeat ($urandom_range(0, 2)) tick();
            end
            cfg_valid = 1'($urandom_range(0, 3) == 0);
            cfg_start = 1'($urandom_range(0, 3) == 0);
            tick();
            cfg_valid = 1'b0;
            cfg_start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            $display("[TB] random load %0d: done=%b error=%b low byte %h", it, m_done, cfg_error, config_out[7:0]);
        end

        tick();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
